alu_activity_monitor: RTL
=========================

# alu_activity_monitor

Upstream idle-detection stage for `power_management`: watches the ALU operand/opcode bus and the S3 request and generates the `idle` and `interrupt` (prolonged-idle) inputs that `power_management` consumes. These outputs replace bench-driven idle/interrupt stimulus. A saturating quiet-cycle counter plus a 4-state FSM grades inactivity into IDLE and DEEP levels. A timed WAKE window releases the power-down chain cleanly on renewed activity.

## Interface
- `IDLE_THRESH`, default 5: consecutive quiet edges before `idle` asserts; must be ≥1.
- `DEEP_THRESH`, default 10: consecutive quiet edges before `interrupt` asserts; must be > `IDLE_THRESH` and ≤ 2^`CNT_W`−1.
- `WAKE_CYCLES`, default 2: edges spent in WAKE before returning to ACTIVE; must be ≥1.
- `CNT_W`, default 8: quiet counter width.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `a`  in  4  ALU operand A.
- `b`  in  4  ALU operand B.
- `opcode`  in  2  ALU opcode.
- `s3_state`  in  1  S3 entry request, level.
- `wake_req`  in  1  external wake event, level-sampled each edge.
- `idle`  out  1  to `power_management.idle`; high in IDLE and DEEP.
- `interrupt`  out  1  to `power_management.interrupt`; high in DEEP only.
- `wake`  out  1  one-cycle pulse on entry to WAKE.
- `state`  out  2  current FSM state encoding.
- `quiet_cnt`  out  `CNT_W`  current consecutive-quiet count.

## Operation
- `prev_{a,b,opcode}` registers capture the inputs every edge; reset value 0.
- `activity` (combinational) = ({a,b,opcode} ≠ prev) OR `wake_req`.
- Quiet counter, every edge:
  - If `activity`: 0.
  - Otherwise: +1, saturating at 2^`CNT_W`−1.
  - Forced to 0 on entry to WAKE and on WAKE→ACTIVE.
- FSM transitions, evaluated on the counter's next value:
  - ACTIVE→IDLE when next count == `IDLE_THRESH`, or when `s3_state`=1.
  - IDLE→WAKE when `activity` and `s3_state`=0.
  - Else IDLE→DEEP when next count ≥ `DEEP_THRESH` or `s3_state`=1.
  - DEEP→WAKE when `activity` and `s3_state`=0. DEEP holds while `s3_state`=1 regardless of activity.
  - WAKE→ACTIVE after `WAKE_CYCLES` edges. Activity inside WAKE is ignored and does not extend the window.
- Simultaneous events:
  - In ACTIVE, `s3_state` and `activity` together → IDLE (S3 wins).
  - In IDLE, `activity` with `s3_state`=1 → DEEP.
- All outputs are registered, decoded from the next state.
- Reset values: state ACTIVE, `idle`=0, `interrupt`=0, `wake`=0, `quiet_cnt`=0, prev registers 0. Reset mid-sequence, including in DEEP or WAKE, returns to these values immediately and asynchronously.

## Timing
- `idle` rises at the `IDLE_THRESH`-th consecutive quiet edge after the last active edge.
- `interrupt` rises at the `DEEP_THRESH`-th consecutive quiet edge.
- With `s3_state` asserted from ACTIVE: `idle` rises 1 edge later and `interrupt` 2 edges later.
- On an active edge in IDLE/DEEP:
  - `idle`, `interrupt` fall and `wake`=1 for exactly that following cycle.
  - State returns to ACTIVE `WAKE_CYCLES` edges later.
- A single input change produces exactly one active edge, because prev updates every cycle.
- Inputs that are constant but nonzero count as quiet.
- No handshake; outputs are levels, stable between edges.

## Structure
- Shared package `pm_pkg`:
  - `pm_state_e` enum: ACTIVE=2'b00, IDLE=2'b01, DEEP=2'b10, WAKE=2'b11.
  - Default threshold constants `PM_IDLE_THRESH`, `PM_DEEP_THRESH`, `PM_WAKE_CYCLES`.
- Sub-module `quiet_counter`: parameterised saturating counter with `clr` and `inc` inputs. The same counter also serves the WAKE window timer.
- Parameter legality checked by elaboration-time assertions.

## Test plan
- Reset asserted at an arbitrary mid-cycle time → all outputs 0 and state=ACTIVE before the next edge; holds through reset.
- a=4, b=5, op=00, then held constant (defaults) → `idle`=1 at the 5th quiet edge, `interrupt`=1 at the 10th, `quiet_cnt`=10.
- From DEEP, change a 4→7 → next cycle `idle`=0, `interrupt`=0, `wake`=1 for 1 cycle; state=ACTIVE 2 edges later, `quiet_cnt`=0.
- `s3_state`=1 while active with inputs toggling every cycle → `idle` after 1 edge, `interrupt` after 2; toggling inputs do not exit DEEP until `s3_state`=0.
- `wake_req` pulse in IDLE with a, b, op constant → WAKE entered; a second pulse inside WAKE does not extend the window.
- `CNT_W`=3, `DEEP_THRESH`=7, quiet for 20 edges → `quiet_cnt` saturates at 7, no wrap, state stays DEEP.

Source files
------------

// File: rtl/pm_pkg.sv
// Purpose: shared state encoding and default thresholds for the ALU idle monitor.
// Latency: n/a (types, constants and a decode helper only).
// Backpressure: n/a.
package pm_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'b00,
        IDLE   = 2'b01,
        DEEP   = 2'b10,
        WAKE   = 2'b11
    } pm_state_e;

    localparam int PM_IDLE_THRESH = 5;
    localparam int PM_DEEP_THRESH = 10;
    localparam int PM_WAKE_CYCLES = 2;
    localparam int PM_CNT_W       = 8;

    // Both graded inactivity levels drive the downstream idle input.
    function automatic logic pm_is_idle(input pm_state_e s);
        return (s == IDLE) || (s == DEEP);
    endfunction

endpackage

// File: rtl/quiet_counter.sv
// Purpose: saturating up-counter with synchronous clear; used for quiet runs and the wake window.
// Latency: count updates on the edge after clr/inc; cnt_adv is the combinational saturated cnt+1.
// Backpressure: none; clr has priority over inc, counting stops at all-ones.
module quiet_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_adv
);

    localparam logic [W-1:0] CNT_MAX = '1;

    // Saturated advance is exposed so the owner can decide on it before the edge.
    assign cnt_adv = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;

    // Counter register: clear wins, otherwise advance when enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt_adv;
        end
    end

endmodule

// File: rtl/alu_activity_monitor.sv
// Purpose: grades ALU bus inactivity into IDLE/DEEP levels and produces idle/interrupt/wake for power management.
// Latency: outputs registered from next state; idle on the IDLE_THRESH-th quiet edge, wake pulse the cycle after activity.
// Backpressure: none; outputs are free-running levels, stable between edges.
module alu_activity_monitor
    import pm_pkg::*;
#(
    parameter int IDLE_THRESH = PM_IDLE_THRESH,
    parameter int DEEP_THRESH = PM_DEEP_THRESH,
    parameter int WAKE_CYCLES = PM_WAKE_CYCLES,
    parameter int CNT_W       = PM_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic [1:0]       opcode,
    input  logic             s3_state,
    input  logic             wake_req,
    output logic             idle,
    output logic             interrupt,
    output logic             wake,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] quiet_cnt
);

    if (IDLE_THRESH < 1) begin : g_bad_idle_thresh
        $error("alu_activity_monitor: IDLE_THRESH must be at least 1");
    end
    if (DEEP_THRESH <= IDLE_THRESH) begin : g_bad_deep_order
        $error("alu_activity_monitor: DEEP_THRESH must exceed IDLE_THRESH");
    end
    if (DEEP_THRESH > (2 ** CNT_W) - 1) begin : g_bad_deep_range
        $error("alu_activity_monitor: DEEP_THRESH must fit in CNT_W bits");
    end
    if (WAKE_CYCLES < 1) begin : g_bad_wake_cycles
        $error("alu_activity_monitor: WAKE_CYCLES must be at least 1");
    end

    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);

    localparam logic [CNT_W-1:0]  IDLE_T = CNT_W'(IDLE_THRESH);
    localparam logic [CNT_W-1:0]  DEEP_T = CNT_W'(DEEP_THRESH);
    localparam logic [WAKE_W-1:0] WAKE_T = WAKE_W'(WAKE_CYCLES);

    pm_state_e         st_q;
    pm_state_e         st_nxt;
    logic [3:0]        prev_a;
    logic [3:0]        prev_b;
    logic [1:0]        prev_op;
    logic              activity;
    logic [CNT_W-1:0]  q_adv;
    logic [CNT_W-1:0]  q_raw;
    logic [WAKE_W-1:0] w_cnt;
    logic [WAKE_W-1:0] w_adv;
    logic              wake_entry;
    logic              wake_exit;

    // Any bus change since the previous edge, or an explicit wake request, is activity.
    assign activity = ({a, b, opcode} != {prev_a, prev_b, prev_op}) || wake_req;

    // Quiet count this edge would produce before the WAKE-boundary clears.
    assign q_raw = activity ? '0 : q_adv;

    // Next-state decision; S3 dominates activity in ACTIVE and IDLE, and pins DEEP.
    always_comb begin
        st_nxt = st_q;
        case (st_q)
            ACTIVE: if (s3_state || (q_raw == IDLE_T)) st_nxt = IDLE;
            IDLE: begin
                if (activity && !s3_state)             st_nxt = WAKE;
                else if ((q_raw >= DEEP_T) || s3_state) st_nxt = DEEP;
            end
            DEEP:   if (activity && !s3_state) st_nxt = WAKE;
            WAKE:   if (w_adv == WAKE_T) st_nxt = ACTIVE;
            default: st_nxt = ACTIVE;
        endcase
    end

    assign wake_entry = (st_nxt == WAKE) && (st_q != WAKE);
    assign wake_exit  = (st_q == WAKE) && (st_nxt == ACTIVE);

    quiet_counter #(.W(CNT_W)) u_quiet_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (activity || wake_entry || wake_exit),
        .inc     (1'b1),
        .cnt     (quiet_cnt),
        .cnt_adv (q_adv)
    );

    // Wake window timer: idle at zero outside WAKE, never advances past the window length.
    quiet_counter #(.W(WAKE_W)) u_wake_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (st_nxt != WAKE),
        .inc     ((st_q == WAKE) && (w_cnt != WAKE_T)),
        .cnt     (w_cnt),
        .cnt_adv (w_adv)
    );

    // State, input history and outputs decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q      <= ACTIVE;
            prev_a    <= '0;
            prev_b    <= '0;
            prev_op   <= '0;
            idle      <= 1'b0;
            interrupt <= 1'b0;
            wake      <= 1'b0;
        end else begin
            st_q      <= st_nxt;
            prev_a    <= a;
            prev_b    <= b;
            prev_op   <= opcode;
            idle      <= pm_is_idle(st_nxt);
            interrupt <= (st_nxt == DEEP);
            wake      <= wake_entry;
        end
    end

    assign state = st_q;

endmodule
